// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with frame-coherent shadow, blinking,
// leading-zero blanking and a one-cycle blanking gap between digits.
module seg_scan_driver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        show,
    input  logic        second,
    input  logic [23:0] digits,
    input  logic [2:0]  blink_sel,
    input  logic        lz_blank,
    output logic [5:0]  an,
    output logic [7:0]  seg
);

    localparam logic StGap   = 1'b0;
    localparam logic StDrive = 1'b1;

    localparam logic [2:0] LastIdx = 3'd5;

    logic [2:0]  idx_q, idx_d;
    logic        phase_q, phase_d;
    logic [23:0] shadow_q, shadow_d;
    logic        state_q, state_d;
    logic        pend_q, pend_d;
    logic [5:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;

    logic        idx_wrap;
    logic [2:0]  idx_next;
    logic [3:0]  cur_nibble;
    logic        cur_blink_en;
    logic [6:0]  cur_code;
    logic [7:0]  drive_seg;
    logic [5:0]  drive_an;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = 7'h3F;
            4'd1:    c = 7'h06;
            4'd2:    c = 7'h5B;
            4'd3:    c = 7'h4F;
            4'd4:    c = 7'h66;
            4'd5:    c = 7'h6D;
            4'd6:    c = 7'h7D;
            4'd7:    c = 7'h07;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h6F;
            default: c = 7'h40;
        endcase
        return c;
    endfunction

    assign idx_wrap = (idx_q >= LastIdx);
    assign idx_next = idx_wrap ? 3'd0 : idx_q + 3'd1;

    always_comb begin
        cur_nibble   = 4'd0;
        cur_blink_en = 1'b0;
        case (idx_q)
            3'd0: begin cur_nibble = shadow_q[3:0];   cur_blink_en = blink_sel[0]; end
            3'd1: begin cur_nibble = shadow_q[7:4];   cur_blink_en = blink_sel[0]; end
            3'd2: begin cur_nibble = shadow_q[11:8];  cur_blink_en = blink_sel[1]; end
            3'd3: begin cur_nibble = shadow_q[15:12]; cur_blink_en = blink_sel[1]; end
            3'd4: begin cur_nibble = shadow_q[19:16]; cur_blink_en = blink_sel[2]; end
            3'd5: begin cur_nibble = shadow_q[23:20]; cur_blink_en = blink_sel[2]; end
            default: begin cur_nibble = 4'd0; cur_blink_en = 1'b0; end
        endcase
    end

    // Blink and leading-zero blanking clear only the digit segments, never the separator dot.
    always_comb begin
        cur_code = seg_code(cur_nibble);
        if (cur_blink_en && phase_q) begin
            cur_code = 7'h00;
        end
        if ((idx_q == LastIdx) && lz_blank && (cur_nibble == 4'd0)) begin
            cur_code = 7'h00;
        end
        drive_seg[6:0] = cur_code;
        drive_seg[7]   = ((idx_q == 3'd2) || (idx_q == 3'd4)) && !phase_q;
        drive_an       = 6'b000001 << idx_q;
    end

    always_comb begin
        idx_d    = idx_q;
        phase_d  = phase_q ^ second;
        shadow_d = shadow_q;
        state_d  = state_q;
        pend_d   = pend_q;
        an_d     = an_q;
        seg_d    = seg_q;

        if (show) begin
            idx_d   = idx_next;
            state_d = StGap;
            pend_d  = 1'b1;
            an_d    = 6'b0;
            seg_d   = 8'h00;
            // Latch a whole new frame only at the wrap so a scan never mixes two times.
            if (idx_wrap) begin
                shadow_d = digits;
            end
        end else if ((state_q == StGap) && pend_q) begin
            state_d = StDrive;
            pend_d  = 1'b0;
            an_d    = drive_an;
            seg_d   = drive_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= 3'd0;
            phase_q  <= 1'b0;
            shadow_q <= 24'h0;
            state_q  <= StGap;
            pend_q   <= 1'b0;
            an_q     <= 6'b0;
            seg_q    <= 8'h00;
        end else begin
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
